sap_core: RTL and testbench
===========================

// Module: sap_core
// PURPOSE
//   Parametrised successor to the SAP-1 top: a complete accumulator CPU with its own
//   controller, PC, MAR, IR, A, B, ALU, flags and output register.
//   Program/data memory sits outside the core, behind a simple RAM port.
//   Adds over SAP-1: generic data width, STA, JMP/JZ/JC, Z/C flags, halted status and an
//   optional OUT handshake.
//   Internal transfers use a muxed bus; there are no tristates inside the core.
// PARAMETERS
//   DATA_W    8  word width; minimum 6; instruction = {opcode[3:0], operand[ADDR_W-1:0]}
//   PC_RESET  0  PC value loaded on reset
//   (localparam ADDR_W = DATA_W-4)
// PORTS
//   CLK        in   1       clock; all state changes on the rising edge
//   CLR        in   1       reset, asynchronous, active-low
//   mem_addr   out  ADDR_W  memory address; equals the MAR register
//   mem_rdata  in   DATA_W  combinational read data for mem_addr, valid in the same cycle
//   mem_wdata  out  DATA_W  write data (always driven from A)
//   mem_we     out  1       write strobe; memory writes on the CLK edge ending the cycle
//   out_data   out  DATA_W  output register
//   out_valid  out  1       out_data updated / being offered
//   out_ready  in   1       sink accepts out_data (used only with SAP_OUT_HANDSHAKE_EN)
//   halted     out  1       HLT executed; core frozen until reset
// BEHAVIOUR
//   Reset (CLR=0), asynchronous, effective at any T-state:
//     PC=PC_RESET, MAR=0, IR=0, A=B=0, Z=C=0, out_data=0, out_valid=0, mem_we=0,
//     halted=0, T-state=T1.
//   Every instruction takes exactly 6 T-states (T1..T6), unless stalled by the OUT handshake.
//   Instruction k starts at cycle 6k+1 after CLR rises.
//   Fetch:
//     T1  MAR<=PC
//     T2  PC<=PC+1 (wraps 2^ADDR_W-1 -> 0)
//     T3  IR<=mem_rdata
//   Execute, by opcode:
//     LDA 0000  T4 MAR<=op; T5 A<=mem_rdata, Z<=(A_new==0)
//     ADD 0001  T4 MAR<=op; T5 B<=mem_rdata; T6 {C,A}<=A+B, Z<=(A_new==0)
//     SUB 0010  T4 MAR<=op; T5 B<=mem_rdata; T6 {C,A}<=A+~B+1, Z<=(A_new==0)
//               (C=1 means A>=B, unsigned)
//     JMP 0011  T4 PC<=op
//     JZ  0100  T4 PC<=op if Z
//     JC  0101  T4 PC<=op if C
//     STA 0110  T4 MAR<=op; T5 mem_we=1 (combinational, T5 only), mem_wdata=A
//     OUT 1110  T4 out_data<=A, out_valid<=1
//     HLT 1111  T4 halted<=1; T-state, PC, MAR and all registers freeze
//     others    NOP; all 6 T-states run
//   Unused T-states are idle. Flags change only on LDA/ADD/SUB; C is unchanged by LDA.
//   Halted: mem_we=0 and out_valid=0 while halted; only CLR low leaves the halted state.
// CONFIGURATION
//   SAP_OUT_HANDSHAKE_EN defined:
//     During T5 of OUT, the T-state holds while out_valid && !out_ready.
//     On the first T5 cycle with out_ready=1: out_valid<=0 and advance to T6.
//     out_data is stable while valid.
//   SAP_OUT_HANDSHAKE_EN undefined:
//     out_valid is a 1-cycle pulse in T5; out_ready is ignored; there is never a stall.
// STRUCTURE
//   sap_pkg: opcode localparams (OP_LDA..OP_HLT), T-state enum T1..T6, ADDR_W derivation helper.
//   Sub-module sap_tstate_ctr: one-hot 6-state ring counter with a hold input
//     (stall/halt) and async active-low reset to T1.
//   Decode and datapath sit in sap_core.
// TESTING
//   1 CLR pulsed low in T5 of an ADD -> all regs 0, mem_addr=0, next fetch from PC_RESET,
//     no mem_we.
//   2 mem[0..3]=LDA 9, ADD 10, OUT, HLT; mem[9]=0x1C, mem[10]=0x0E
//     -> out_data=0x2A, out_valid in cycle 17, halted=1 from cycle 23, mem_addr frozen.
//   3 A=5, SUB of mem=5 -> A=0, Z=1, C=1; JZ 12 taken (fetch at 12).
//     A=3, SUB of 5 -> A=0xFE, C=0; JC not taken.
//   4 STA 7 with A=0x5A -> mem_we=1 only in T5 with mem_addr=7, mem_wdata=0x5A.
//   5 JMP 15, NOP at 15 -> next T1 loads MAR=0 (PC wrap); repeat with DATA_W=12
//     (wrap at 255).
//   6 With handshake: out_ready low 3 cycles at OUT -> T5 held 4 cycles, out_valid held,
//     no fetch; out_ready high -> out_valid drops, T6 follows.

Source files
------------

// File: rtl/sap_pkg.sv
// sap_pkg: opcodes, one-hot T-state encoding, bus source selects and the address-width
// helper shared by the SAP core and its T-state counter.
package sap_pkg;

  localparam logic [3:0] OP_LDA = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_JMP = 4'b0011;
  localparam logic [3:0] OP_JZ  = 4'b0100;
  localparam logic [3:0] OP_JC  = 4'b0101;
  localparam logic [3:0] OP_STA = 4'b0110;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  typedef enum logic [5:0] {
    T1 = 6'b000001,
    T2 = 6'b000010,
    T3 = 6'b000100,
    T4 = 6'b001000,
    T5 = 6'b010000,
    T6 = 6'b100000
  } tstate_e;

  typedef enum logic [2:0] {
    BUS_NONE = 3'd0,
    BUS_PC   = 3'd1,
    BUS_OPND = 3'd2,
    BUS_MEM  = 3'd3,
    BUS_A    = 3'd4,
    BUS_ALU  = 3'd5
  } bus_sel_e;

  // Instruction word is {opcode[3:0], operand}, so the operand keeps the rest.
  function automatic int calc_addr_w(input int data_w);
    return data_w - 32'sd4;
  endfunction

endpackage

// File: rtl/sap_tstate_ctr.sv
// sap_tstate_ctr: one-hot six-state T-state ring counter; hold freezes the current state
// (OUT stall or halt), reset returns to T1.
module sap_tstate_ctr
  import sap_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  logic    hold,
  output tstate_e tstate
);

  tstate_e state_r;
  tstate_e state_next_s;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= T1;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next state: step around the ring unless held
  always_comb begin
    state_next_s = T1;
    if (hold) begin
      state_next_s = state_r;
    end else begin
      case (state_r)
        T1:      state_next_s = T2;
        T2:      state_next_s = T3;
        T3:      state_next_s = T4;
        T4:      state_next_s = T5;
        T5:      state_next_s = T6;
        T6:      state_next_s = T1;
        default: state_next_s = T1;
      endcase
    end
  end

  assign tstate = state_r;

endmodule

// File: rtl/sap_core.sv
// sap_core: parametrised SAP-style accumulator CPU (PC, MAR, IR, A, B, ALU, Z/C, OUT) with
// an external RAM port. Build macro SAP_OUT_HANDSHAKE_EN stalls OUT in T5 until out_ready.
module sap_core
  import sap_pkg::*;
#(
  parameter  int DATA_W   = 8,
  parameter  int PC_RESET = 0,
  localparam int ADDR_W   = calc_addr_w(DATA_W)
) (
  input  logic              CLK,
  input  logic              CLR,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              halted
);

  localparam logic [ADDR_W-1:0] PC_INIT = ADDR_W'(PC_RESET);

  logic [ADDR_W-1:0] pc_r;
  logic [ADDR_W-1:0] mar_r;
  logic [DATA_W-1:0] ir_r;
  logic [DATA_W-1:0] a_r;
  logic [DATA_W-1:0] b_r;
  logic              z_r;
  logic              c_r;
  logic [DATA_W-1:0] out_data_r;
  logic              out_valid_r;
  logic              halted_r;

  tstate_e           tstate_s;
  logic [3:0]        opcode_s;
  logic [ADDR_W-1:0] operand_s;
  bus_sel_e          bus_sel_s;
  logic [DATA_W-1:0] bus_s;
  logic [DATA_W-1:0] b_opnd_s;
  logic [DATA_W:0]   alu_s;
  logic              pc_inc_s;
  logic              pc_load_s;
  logic              mar_load_s;
  logic              ir_load_s;
  logic              a_load_s;
  logic              b_load_s;
  logic              z_load_s;
  logic              c_load_s;
  logic              alu_sub_s;
  logic              we_s;
  logic              out_load_s;
  logic              out_clr_s;
  logic              halt_s;
  logic              stall_s;
  logic              hold_s;
  logic              unused_ok_s;

  assign opcode_s  = ir_r[DATA_W-1 -: 4];
  assign operand_s = ir_r[ADDR_W-1:0];
  // Without the handshake the sink is never consulted.
  assign unused_ok_s = out_ready;

  assign hold_s = halted_r | halt_s | stall_s;

  sap_tstate_ctr u_tstate (
    .clk    (CLK),
    .rst_n  (CLR),
    .hold   (hold_s),
    .tstate (tstate_s)
  );

  // SUB is A + ~B + 1, so carry out means no borrow (A >= B).
  assign b_opnd_s = alu_sub_s ? ~b_r : b_r;
  assign alu_s    = {1'b0, a_r} + {1'b0, b_opnd_s} + {{DATA_W{1'b0}}, alu_sub_s};

  // Internal transfer bus: one source selected per T-state
  always_comb begin
    bus_s = '0;
    case (bus_sel_s)
      BUS_PC:   bus_s = DATA_W'(pc_r);
      BUS_OPND: bus_s = DATA_W'(operand_s);
      BUS_MEM:  bus_s = mem_rdata;
      BUS_A:    bus_s = a_r;
      BUS_ALU:  bus_s = alu_s[DATA_W-1:0];
      default:  bus_s = '0;
    endcase
  end

  // Controller: decode T-state and opcode into transfer strobes
  always_comb begin
    bus_sel_s  = BUS_NONE;
    pc_inc_s   = 1'b0;
    pc_load_s  = 1'b0;
    mar_load_s = 1'b0;
    ir_load_s  = 1'b0;
    a_load_s   = 1'b0;
    b_load_s   = 1'b0;
    z_load_s   = 1'b0;
    c_load_s   = 1'b0;
    alu_sub_s  = 1'b0;
    we_s       = 1'b0;
    out_load_s = 1'b0;
    out_clr_s  = 1'b0;
    halt_s     = 1'b0;
    stall_s    = 1'b0;
    if (halted_r) begin
      bus_sel_s = BUS_NONE;
    end else begin
      case (tstate_s)
        T1: begin
          bus_sel_s  = BUS_PC;
          mar_load_s = 1'b1;
        end
        T2: pc_inc_s = 1'b1;
        T3: begin
          bus_sel_s = BUS_MEM;
          ir_load_s = 1'b1;
        end
        T4: begin
          case (opcode_s)
            OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
              bus_sel_s  = BUS_OPND;
              mar_load_s = 1'b1;
            end
            OP_JMP: begin
              bus_sel_s = BUS_OPND;
              pc_load_s = 1'b1;
            end
            OP_JZ: begin
              bus_sel_s = BUS_OPND;
              pc_load_s = z_r;
            end
            OP_JC: begin
              bus_sel_s = BUS_OPND;
              pc_load_s = c_r;
            end
            OP_OUT: begin
              bus_sel_s  = BUS_A;
              out_load_s = 1'b1;
            end
            OP_HLT:  halt_s = 1'b1;
            default: halt_s = 1'b0;
          endcase
        end
        T5: begin
          case (opcode_s)
            OP_LDA: begin
              bus_sel_s = BUS_MEM;
              a_load_s  = 1'b1;
              z_load_s  = 1'b1;
            end
            OP_ADD, OP_SUB: begin
              bus_sel_s = BUS_MEM;
              b_load_s  = 1'b1;
            end
            OP_STA: we_s = 1'b1;
            OP_OUT: begin
`ifdef SAP_OUT_HANDSHAKE_EN
              stall_s   = out_valid_r & ~out_ready;
              out_clr_s = out_ready;
`else
              out_clr_s = 1'b1;
`endif
            end
            default: we_s = 1'b0;
          endcase
        end
        T6: begin
          if ((opcode_s == OP_ADD) || (opcode_s == OP_SUB)) begin
            alu_sub_s = (opcode_s == OP_SUB);
            bus_sel_s = BUS_ALU;
            a_load_s  = 1'b1;
            z_load_s  = 1'b1;
            c_load_s  = 1'b1;
          end else begin
            bus_sel_s = BUS_NONE;
          end
        end
        default: bus_sel_s = BUS_NONE;
      endcase
    end
  end

  // Program counter, memory address register and instruction register
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      pc_r  <= PC_INIT;
      mar_r <= '0;
      ir_r  <= '0;
    end else begin
      if (pc_load_s) begin
        pc_r <= bus_s[ADDR_W-1:0];
      end else if (pc_inc_s) begin
        pc_r <= pc_r + ADDR_W'(1'b1);
      end
      if (mar_load_s) begin
        mar_r <= bus_s[ADDR_W-1:0];
      end
      if (ir_load_s) begin
        ir_r <= bus_s;
      end
    end
  end

  // Accumulator, B operand and flags
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      a_r <= '0;
      b_r <= '0;
      z_r <= 1'b0;
      c_r <= 1'b0;
    end else begin
      if (a_load_s) begin
        a_r <= bus_s;
      end
      if (b_load_s) begin
        b_r <= bus_s;
      end
      if (z_load_s) begin
        z_r <= (bus_s == '0);
      end
      if (c_load_s) begin
        c_r <= alu_s[DATA_W];
      end
    end
  end

  // Output register, its valid flag and the halt latch
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      out_data_r  <= '0;
      out_valid_r <= 1'b0;
      halted_r    <= 1'b0;
    end else begin
      if (out_load_s) begin
        out_data_r  <= bus_s;
        out_valid_r <= 1'b1;
      end else if (out_clr_s || halt_s) begin
        out_valid_r <= 1'b0;
      end
      if (halt_s) begin
        halted_r <= 1'b1;
      end
    end
  end

  assign mem_addr  = mar_r;
  assign mem_wdata = a_r;
  assign mem_we    = we_s;
  assign out_data  = out_data_r;
  assign out_valid = out_valid_r;
  assign halted    = halted_r;

endmodule

// File: tb/tb_sap_core.sv
// tb_sap_core: directed self-checking bench for sap_core (8-bit main instance, 12-bit
// instance for the address wrap). Cycle n is the n-th clock period after CLR rises.
module tb_sap_core;

  logic        clk = 1'b0;
  logic        CLR;
  logic        out_ready;
  logic [3:0]  mem_addr;
  logic [7:0]  mem_rdata;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        halted;
  logic [7:0]  mem [16];

  logic [7:0]  addr12;
  logic [11:0] rdata12;
  logic [11:0] mem12 [256];
  logic [11:0] unused_wdata12;
  logic        unused_we12;
  logic [11:0] unused_out12;
  logic        unused_valid12;
  logic        unused_halt12;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  int cyc      = 0;

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];
  assign rdata12   = mem12[addr12];

  sap_core #(.DATA_W(8), .PC_RESET(0)) dut (
    .CLK(clk), .CLR(CLR), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .mem_wdata(mem_wdata), .mem_we(mem_we), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .halted(halted)
  );

  sap_core #(.DATA_W(12), .PC_RESET(0)) dut12 (
    .CLK(clk), .CLR(CLR), .mem_addr(addr12), .mem_rdata(rdata12),
    .mem_wdata(unused_wdata12), .mem_we(unused_we12), .out_data(unused_out12),
    .out_valid(unused_valid12), .out_ready(1'b1), .halted(unused_halt12)
  );

  task automatic next_cycle();
    @(negedge clk);
    cyc++;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) next_cycle();
  endtask

  task automatic fill_nop();
    for (int i = 0; i < 16; i++) mem[i] = 8'h70;
  endtask

  task automatic hold_reset();
    CLR = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1 CLR = 1'b1;
    cyc = 0;
  endtask

  task automatic test_reset();
    hold_reset();
    chk_cnt++; if (mem_addr !== 4'h0) $display("FAIL reset_mem_addr: got %h want 0", mem_addr); else pass_cnt++;
    chk_cnt++; if (out_data !== 8'h00) $display("FAIL reset_out_data: got %h want 00", out_data); else pass_cnt++;
    chk_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else pass_cnt++;
    chk_cnt++; if (mem_we !== 1'b0) $display("FAIL reset_mem_we: got %b want 0", mem_we); else pass_cnt++;
    chk_cnt++; if (halted !== 1'b0) $display("FAIL reset_halted: got %b want 0", halted); else pass_cnt++;
  endtask

  task automatic load_add_prog();
    fill_nop();
    mem[0] = 8'h09; mem[1] = 8'h1A; mem[2] = 8'hE0; mem[3] = 8'hF0;
    mem[9] = 8'h1C; mem[10] = 8'h0E;
  endtask

  task automatic test_clr_mid_add();
    load_add_prog();
    hold_reset();
    release_reset();
    run_to(11);
    chk_cnt++; if (mem_addr !== 4'hA) $display("FAIL clr_pre_t5_addr: got %h want a", mem_addr); else pass_cnt++;
    #1 CLR = 1'b0;
    #1;
    chk_cnt++; if (mem_addr !== 4'h0) $display("FAIL clr_async_addr: got %h want 0", mem_addr); else pass_cnt++;
    chk_cnt++; if (mem_we !== 1'b0) $display("FAIL clr_async_we: got %b want 0", mem_we); else pass_cnt++;
    chk_cnt++; if (out_data !== 8'h00) $display("FAIL clr_async_out: got %h want 00", out_data); else pass_cnt++;
    release_reset();
    for (int i = 0; i < 8; i++) begin
      next_cycle();
      chk_cnt++; if (mem_we !== 1'b0) $display("FAIL clr_after_we cyc %0d: got %b want 0", cyc, mem_we); else pass_cnt++;
    end
    // cyc is 8: second fetch from PC_RESET+1
    chk_cnt++; if (mem_addr !== 4'h1) $display("FAIL clr_refetch_addr: got %h want 1", mem_addr); else pass_cnt++;
  endtask

  task automatic test_program();
    load_add_prog();
    hold_reset();
    release_reset();
    for (int i = 0; i < 30; i++) begin
      next_cycle();
      if (cyc == 2) begin
        chk_cnt++; if (mem_addr !== 4'h0) $display("FAIL prog_first_fetch: got %h want 0", mem_addr); else pass_cnt++;
      end
      chk_cnt++; if (out_valid !== (cyc == 17)) $display("FAIL prog_out_valid cyc %0d: got %b want %b", cyc, out_valid, (cyc == 17)); else pass_cnt++;
      chk_cnt++; if (halted !== (cyc >= 23)) $display("FAIL prog_halted cyc %0d: got %b want %b", cyc, halted, (cyc >= 23)); else pass_cnt++;
      chk_cnt++; if (mem_we !== 1'b0) $display("FAIL prog_mem_we cyc %0d: got %b want 0", cyc, mem_we); else pass_cnt++;
    end
    chk_cnt++; if (out_data !== 8'h2A) $display("FAIL prog_out_data: got %h want 2a", out_data); else pass_cnt++;
    chk_cnt++; if (mem_addr !== 4'h3) $display("FAIL prog_addr_frozen: got %h want 3", mem_addr); else pass_cnt++;
  endtask

  task automatic test_sub_jump();
    fill_nop();
    mem[0] = 8'h0A; mem[1] = 8'h2A; mem[2] = 8'h4C; mem[3] = 8'hF0;
    mem[4] = 8'h0B; mem[5] = 8'h2A; mem[6] = 8'h5E; mem[7] = 8'hE0;
    mem[8] = 8'hF0; mem[10] = 8'h05; mem[11] = 8'h03;
    mem[12] = 8'h54; mem[13] = 8'hF0; mem[14] = 8'hF0;
    hold_reset();
    release_reset();
    run_to(14);
    chk_cnt++; if (mem_addr !== 4'h2) $display("FAIL sub_jz_fetch: got %h want 2", mem_addr); else pass_cnt++;
    run_to(20);
    chk_cnt++; if (mem_addr !== 4'hC) $display("FAIL sub_jz_taken: got %h want c", mem_addr); else pass_cnt++;
    run_to(26);
    chk_cnt++; if (mem_addr !== 4'h4) $display("FAIL sub_jc_taken: got %h want 4", mem_addr); else pass_cnt++;
    run_to(44);
    chk_cnt++; if (mem_addr !== 4'h7) $display("FAIL sub_jc_not_taken: got %h want 7", mem_addr); else pass_cnt++;
    run_to(47);
    chk_cnt++; if (out_valid !== 1'b1) $display("FAIL sub_out_valid: got %b want 1", out_valid); else pass_cnt++;
    chk_cnt++; if (out_data !== 8'hFE) $display("FAIL sub_result: got %h want fe", out_data); else pass_cnt++;
    run_to(56);
    chk_cnt++; if (halted !== 1'b1) $display("FAIL sub_halted: got %b want 1", halted); else pass_cnt++;
    chk_cnt++; if (mem_addr !== 4'h8) $display("FAIL sub_halt_addr: got %h want 8", mem_addr); else pass_cnt++;
  endtask

  task automatic test_sta();
    fill_nop();
    mem[0] = 8'h0A; mem[1] = 8'h67; mem[2] = 8'hF0; mem[10] = 8'h5A;
    hold_reset();
    release_reset();
    for (int i = 0; i < 14; i++) begin
      next_cycle();
      chk_cnt++; if (mem_we !== (cyc == 11)) $display("FAIL sta_we cyc %0d: got %b want %b", cyc, mem_we, (cyc == 11)); else pass_cnt++;
      if (cyc == 11) begin
        chk_cnt++; if (mem_addr !== 4'h7) $display("FAIL sta_addr: got %h want 7", mem_addr); else pass_cnt++;
        chk_cnt++; if (mem_wdata !== 8'h5A) $display("FAIL sta_wdata: got %h want 5a", mem_wdata); else pass_cnt++;
      end
    end
  endtask

  task automatic test_pc_wrap();
    fill_nop();
    mem[0] = 8'h3F; mem[15] = 8'h70;
    hold_reset();
    release_reset();
    run_to(8);
    chk_cnt++; if (mem_addr !== 4'hF) $display("FAIL wrap8_jmp: got %h want f", mem_addr); else pass_cnt++;
    chk_cnt++; if (addr12 !== 8'hFF) $display("FAIL wrap12_jmp: got %h want ff", addr12); else pass_cnt++;
    run_to(14);
    chk_cnt++; if (mem_addr !== 4'h0) $display("FAIL wrap8_pc: got %h want 0", mem_addr); else pass_cnt++;
    chk_cnt++; if (addr12 !== 8'h00) $display("FAIL wrap12_pc: got %h want 00", addr12); else pass_cnt++;
  endtask

  task automatic test_out_port();
    fill_nop();
    mem[0] = 8'h0A; mem[1] = 8'hE0; mem[2] = 8'hF0; mem[10] = 8'h3C;
    out_ready = 1'b0;
    hold_reset();
    release_reset();
    run_to(10);
    chk_cnt++; if (out_valid !== 1'b0) $display("FAIL out_pre_valid: got %b want 0", out_valid); else pass_cnt++;
`ifdef SAP_OUT_HANDSHAKE_EN
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      chk_cnt++; if (out_valid !== 1'b1) $display("FAIL hs_valid_held cyc %0d: got %b want 1", cyc, out_valid); else pass_cnt++;
      chk_cnt++; if (out_data !== 8'h3C) $display("FAIL hs_data cyc %0d: got %h want 3c", cyc, out_data); else pass_cnt++;
      chk_cnt++; if (mem_addr !== 4'h1) $display("FAIL hs_no_fetch cyc %0d: got %h want 1", cyc, mem_addr); else pass_cnt++;
      out_ready = (cyc >= 14);
    end
    next_cycle();
    chk_cnt++; if (out_valid !== 1'b0) $display("FAIL hs_valid_drop: got %b want 0", out_valid); else pass_cnt++;
    run_to(17);
    chk_cnt++; if (mem_addr !== 4'h2) $display("FAIL hs_next_fetch: got %h want 2", mem_addr); else pass_cnt++;
    run_to(21);
    chk_cnt++; if (halted !== 1'b1) $display("FAIL hs_halted: got %b want 1", halted); else pass_cnt++;
`else
    next_cycle();
    chk_cnt++; if (out_valid !== 1'b1) $display("FAIL pulse_valid: got %b want 1", out_valid); else pass_cnt++;
    chk_cnt++; if (out_data !== 8'h3C) $display("FAIL pulse_data: got %h want 3c", out_data); else pass_cnt++;
    next_cycle();
    chk_cnt++; if (out_valid !== 1'b0) $display("FAIL pulse_end: got %b want 0", out_valid); else pass_cnt++;
    run_to(14);
    chk_cnt++; if (mem_addr !== 4'h2) $display("FAIL pulse_no_stall: got %h want 2", mem_addr); else pass_cnt++;
    run_to(18);
    chk_cnt++; if (halted !== 1'b1) $display("FAIL pulse_halted: got %b want 1", halted); else pass_cnt++;
`endif
    chk_cnt++; if (out_data !== 8'h3C) $display("FAIL out_data_kept: got %h want 3c", out_data); else pass_cnt++;
    out_ready = 1'b0;
  endtask

  initial begin
    CLR       = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 256; i++) mem12[i] = 12'h700;
    mem12[0] = 12'h3FF;
    fill_nop();
    test_reset();
    test_clr_mid_add();
    test_program();
    test_sub_jump();
    test_sta();
    test_pc_wrap();
    test_out_port();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
